// File: rtl/twenty_bit_logic_sequencer_pkg.sv
// Package for the 20-bit logic sequencer.
// Contents:
//   - Default datapath width and chunk size.
//   - Opcode enum op_e: 00 OR, 01 AND, 10 XOR, 11 NOR.
//   - FSM state enum state_e: IDLE, BUSY, DONE.
//   - apply_op: bitwise operation on one 32-bit-or-narrower slice.
// The enums replace the opcode/state localparams of the former shared
// logic_ops.vh header, with the same 2-bit encodings.
package twenty_bit_logic_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 20;
  localparam int unsigned DEF_CHUNK = 5;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Operates on a 32-bit container; callers use the low bits they need.
  function automatic logic [31:0] apply_op(input op_e op,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
    logic [31:0] r;
    r = '0;
    unique case (op)
      OP_OR:  r = x | y;
      OP_AND: r = x & y;
      OP_XOR: r = x ^ y;
      OP_NOR: r = ~(x | y);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/twenty_bit_logic_sequencer_slice.sv
// chunk_logic_slice: purely combinational bitwise operation on one
// CHUNK-wide slice of the operands.
// Ports:
//   op  in   2      operation select (op_e)
//   a   in   CHUNK  operand A slice
//   b   in   CHUNK  operand B slice
//   y   out  CHUNK  result slice
module chunk_logic_slice
  import twenty_bit_logic_sequencer_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  op_e              op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_OR:  y = a | b;
      OP_AND: y = a & b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/twenty_bit_logic_sequencer.sv
// twenty_bit_logic_sequencer: multi-cycle bitwise logic unit. Accepts an
// operand pair and opcode over a valid/ready request channel, processes
// CHUNK bits per clock (LSB chunk first) through one shared slice, and
// returns the WIDTH-bit result over a valid/ready response channel.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      request accepted when in_valid && in_ready
//   op         in   2      00 OR, 01 AND, 10 XOR, 11 NOR
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   result     out  WIDTH  computed result
//   zero       out  1      result == 0, valid with out_valid
//   parity     out  1      ^result, valid with out_valid
//                          (only when LOGIC_SEQ_PARITY_EN is defined)
// Configuration macro: LOGIC_SEQ_PARITY_EN
module twenty_bit_logic_sequencer
  import twenty_bit_logic_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef LOGIC_SEQ_PARITY_EN
  output logic             parity,
`endif
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("twenty_bit_logic_sequencer: WIDTH must be a multiple of CHUNK");
  end

  state_e           state;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  op_e              op_lat;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_y;
  logic [WIDTH-1:0] res_next;
  logic             last_chunk;

  assign slice_a    = a_lat[k*CHUNK +: CHUNK];
  assign slice_b    = b_lat[k*CHUNK +: CHUNK];
  assign last_chunk = (k == CW'(NCHUNK - 1));

  chunk_logic_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .op (op_lat),
    .a  (slice_a),
    .b  (slice_b),
    .y  (slice_y)
  );

  // Result with the current chunk merged in; zero/parity on the final
  // BUSY cycle are taken from this so they see the complete result.
  always_comb begin
    res_next                     = result;
    res_next[k*CHUNK +: CHUNK]   = slice_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      k         <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      op_lat    <= OP_OR;
`ifdef LOGIC_SEQ_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_lat    <= a;
            b_lat    <= b;
            op_lat   <= op_e'(op);
            k        <= '0;
            in_ready <= 1'b0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          result <= res_next;
          if (last_chunk) begin
            k         <= '0;
            out_valid <= 1'b1;
            zero      <= (res_next == '0);
`ifdef LOGIC_SEQ_PARITY_EN
            parity    <= ^res_next;
`endif
            state     <= S_DONE;
          end else begin
            k <= k + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
`ifdef LOGIC_SEQ_PARITY_EN
            parity    <= 1'b0;
`endif
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          zero      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twenty_bit_logic_sequencer.sv
// Testbench for twenty_bit_logic_sequencer: directed vectors with
// hand-computed results, a queue of expected responses and a monitor
// that checks each response on its handshake.
module tb_twenty_bit_logic_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [19:0] a;
  logic [19:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] result;
  logic        zero;
`ifdef LOGIC_SEQ_PARITY_EN
  logic        parity;
`endif

  typedef struct {
    logic [19:0] res;
    logic        z;
    logic        par;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  twenty_bit_logic_sequencer #(
    .WIDTH (20),
    .CHUNK (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef LOGIC_SEQ_PARITY_EN
    .parity    (parity),
`endif
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [19:0] act,
                       input logic [19:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [19:0] r, input logic z);
    exp_t e;
    e.res = r;
    e.z   = z;
    e.par = ^r;
    sb.push_back(e);
  endtask

  // Monitor: the handshake happens on the next rising edge whenever both
  // out_valid and out_ready are high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 20'(out_valid), 20'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero", 20'(zero), 20'(e.z));
`ifdef LOGIC_SEQ_PARITY_EN
        check("parity", 20'(parity), 20'(e.par));
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_ready", 20'(in_ready), 20'h1);
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [19:0] av,
                       input logic [19:0] bv);
    wait_ready();
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 20'(sb.size()), 20'h0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 20'(in_ready), 20'h1);
    check("reset_out_valid", 20'(out_valid), 20'h0);
    check("reset_result", result, 20'h0);
    check("reset_zero", 20'(zero), 20'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset mid-BUSY discards the operation
    issue(2'b00, 20'hFFFFF, 20'h00000);
    check("busy_in_ready", 20'(in_ready), 20'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 20'(out_valid), 20'h0);
    check("async_rst_in_ready", 20'(in_ready), 20'h1);
    check("async_rst_result", result, 20'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: OR with exact latency
    push(20'h0005F, 1'b0);
    issue(2'b00, 20'h0005F, 20'h00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("latency_early", 20'(out_valid), 20'h0);
    end
    @(posedge clk); #1;
    check("latency_n4", 20'(out_valid), 20'h1);
    drain();

    // 3: AND to zero
    push(20'h00000, 1'b1);
    issue(2'b01, 20'hC0003, 20'h3FFFC);
    drain();

    // 4: XOR to zero, NOR of zeros
    push(20'h00000, 1'b1);
    issue(2'b10, 20'hFFFFF, 20'hFFFFF);
    drain();
    push(20'hFFFFF, 1'b0);
    issue(2'b11, 20'h00000, 20'h00000);
    drain();

    // 5: backpressure, second request held off until after handshake
    out_ready = 1'b0;
    push(20'hABEFE, 1'b0);
    issue(2'b00, 20'hABCDE, 20'h01234);
    repeat (4) @(posedge clk);
    #1;
    check("bp_out_valid", 20'(out_valid), 20'h1);
    in_valid = 1'b1;
    op = 2'b10;
    a  = 20'h12345;
    b  = 20'h0F0F0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result_held", result, 20'hABEFE);
      check("bp_in_ready", 20'(in_ready), 20'h0);
      check("bp_out_valid_held", 20'(out_valid), 20'h1);
    end
    push(20'h1D3B5, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", 20'(in_ready), 20'h1);
    check("post_hs_out_valid", 20'(out_valid), 20'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("second_accepted", 20'(in_ready), 20'h0);
    drain();

    // 6: operand changes after accept are ignored
    push(20'hC0013, 1'b0);
    issue(2'b00, 20'hC0003, 20'h00010);
    a  = 20'hFFFFF;
    b  = 20'h00000;
    op = 2'b01;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
